// File: rtl/light_uart_tx_scheduler.sv
// Round-robin UART transmit scheduler: grants one of NUM_PORTS byte requesters and serialises
// start + CHAR_WIDTH data (LSB first) + STOP_BITS stop bits, then an optional idle gap.
module light_uart_tx_scheduler #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned CHAR_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 3
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic [NUM_PORTS-1:0]              i_req,
  input  logic [NUM_PORTS*CHAR_WIDTH-1:0]   i_data,
  output logic [NUM_PORTS-1:0]              o_gnt,
  input  logic                              i_cts,
  input  logic [31:0]                       i_dbr,
  input  logic [7:0]                        i_gap_bits,
  output logic                              o_txd,
  output logic                              o_busy,
  output logic [$clog2(NUM_PORTS)-1:0]      o_active_port
);

  localparam int unsigned PtrW = $clog2(NUM_PORTS);
  localparam int unsigned IdxW = (CHAR_WIDTH > 1) ? $clog2(CHAR_WIDTH) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StGap} state_e;

  state_e                r_state, w_state_d;
  logic [15:0]           r_cnt, w_cnt_d, r_cpb, w_cpb;
  logic [7:0]            r_bit, w_bit_d, r_gap;
  logic [CHAR_WIDTH-1:0] r_byte, w_byte;
  logic [PtrW-1:0]       r_rr_ptr, r_active, w_winner, w_next_ptr;
  logic                  r_txd, w_txd_d, w_grant, w_found, w_done;
  logic                  w_unused;

  assign w_unused = ^i_dbr[31:12];
  assign w_cpb    = (i_dbr[11:0] == 12'd0) ? 16'd16 : {i_dbr[11:0], 4'b0000};
  assign w_done   = (r_cnt == 16'd0);

  // First requester at or after the round-robin pointer, searching upward with wrap.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = (32'(r_rr_ptr) + i) % NUM_PORTS;
      if (!w_found && i_req[idx[PtrW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = idx[PtrW-1:0];
      end
    end
  end

  always_comb begin
    w_byte = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (w_winner == PtrW'(k)) w_byte = i_data[k*CHAR_WIDTH +: CHAR_WIDTH];
    end
  end

  assign w_next_ptr = (w_winner == PtrW'(NUM_PORTS - 1)) ? '0 : w_winner + 1'b1;
  // Reset gating keeps gnt low while the state register is forced to idle.
  assign w_grant    = (r_state == StIdle) && !i_reset && !i_cts && w_found;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_grant) w_state_d = StStart;
      StStart: if (w_done) w_state_d = StData;
      StData:  if (w_done && r_bit == 8'(CHAR_WIDTH - 1)) w_state_d = StStop;
      StStop:  if (w_done && r_bit == 8'(STOP_BITS - 1)) begin
                 w_state_d = (r_gap == 8'd0) ? StIdle : StGap;
               end
      StGap:   if (w_done && r_bit == r_gap - 8'd1) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_cnt_d = r_cnt;
    w_bit_d = r_bit;
    if (r_state == StIdle) begin
      if (w_grant) begin
        w_cnt_d = w_cpb - 16'd1;
        w_bit_d = '0;
      end
    end else begin
      w_cnt_d = w_done ? r_cpb - 16'd1 : r_cnt - 16'd1;
      if (w_state_d != r_state) w_bit_d = '0;
      else if (w_done)          w_bit_d = r_bit + 8'd1;
    end
  end

  // txd is registered, so its next value follows the next state and bit index.
  always_comb begin
    o_gnt = '0;
    if (w_grant) o_gnt[w_winner] = 1'b1;
    o_busy = (r_state != StIdle);
    case (w_state_d)
      StStart: w_txd_d = 1'b0;
      StData:  w_txd_d = r_byte[w_bit_d[IdxW-1:0]];
      default: w_txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_bit    <= '0;
      r_cpb    <= 16'd16;
      r_gap    <= '0;
      r_byte   <= '0;
      r_rr_ptr <= '0;
      r_active <= '0;
      r_txd    <= 1'b1;
    end else begin
      r_cnt <= w_cnt_d;
      r_bit <= w_bit_d;
      r_txd <= w_txd_d;
      if (w_grant) begin
        r_cpb    <= w_cpb;
        r_gap    <= i_gap_bits;
        r_byte   <= w_byte;
        r_rr_ptr <= w_next_ptr;
        r_active <= w_winner;
      end
    end
  end

  assign o_txd         = r_txd;
  assign o_active_port = r_active;

endmodule

// File: tb/tb_light_uart_tx_scheduler.sv
// Bench for light_uart_tx_scheduler: directed scenarios plus randomized frames checked against
// an arithmetic frame model (bit-time index from cycle offset) and a round-robin pointer model.
module tb_light_uart_tx_scheduler;

  localparam int FRAME_BITS = 1 + 8 + 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic        cts;
  logic [31:0] dbr;
  logic [7:0]  gap_bits;
  logic        txd;
  logic        busy;
  logic [1:0]  active_port;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rr = 0;
  int last_gnt = 0;
  int mid_k = 0;
  int abort_k = 0;
  logic [31:0] mid_dbr = 32'd1;

  light_uart_tx_scheduler #(
    .NUM_PORTS (4),
    .CHAR_WIDTH(8),
    .STOP_BITS (3)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req        (req),
    .i_data       (data),
    .o_gnt        (gnt),
    .i_cts        (cts),
    .i_dbr        (dbr),
    .i_gap_bits   (gap_bits),
    .o_txd        (txd),
    .o_busy       (busy),
    .o_active_port(active_port)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [3:0] r, input int ptr);
    int m;
    m = int'(r);
    for (int i = 0; i < 4; i++) begin
      if (((m >> ((ptr + i) % 4)) & 1) != 0) return (ptr + i) % 4;
    end
    return -1;
  endfunction

  function automatic int cpb_of(input logic [31:0] d);
    int v;
    v = int'(d[11:0]);
    return (v == 0) ? 16 : v * 16;
  endfunction

  // Line level k cycles after the grant: bit-time 0 is start, 1..8 data, rest high.
  function automatic logic exp_txd(input int k, input int cpb, input logic [7:0] b);
    int bi;
    logic [7:0] t;
    bi = (k - 1) / cpb;
    if (bi == 0) return 1'b0;
    if (bi <= 8) begin
      t = b >> (bi - 1);
      return t[0];
    end
    return 1'b1;
  endfunction

  task automatic set_byte(input int p, input logic [7:0] v);
    data = (data & ~(32'hFF << (8 * p))) | (32'(v) << (8 * p));
  endtask

  // Called at the negedge of a cycle where a grant is expected; returns at the negedge of the
  // first idle cycle after the frame (or right after an injected reset).
  task automatic do_frame(input bit hold, input bit noise);
    int p, cpb, gap, len;
    logic [7:0] b;
    p = model_winner(req, rr);
    if (p < 0 || cts) begin
      check("gnt_none", 32'(gnt), 32'd0);
      return;
    end
    check("gnt", 32'(gnt), 32'd1 << p);
    check("busy_grant", 32'(busy), 32'd0);
    b   = 8'(data >> (8 * p));
    cpb = cpb_of(dbr);
    gap = int'(gap_bits);
    len = (FRAME_BITS + gap) * cpb;
    rr  = (p + 1) % 4;
    last_gnt = cyc;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      if (k <= len) begin
        check("txd", 32'(txd), 32'(exp_txd(k, cpb, b)));
        check("busy", 32'(busy), 32'd1);
        check("gnt_mid", 32'(gnt), 32'd0);
      end else begin
        check("busy_end", 32'(busy), 32'd0);
        check("txd_end", 32'(txd), 32'd1);
        check("active_hold", 32'(active_port), 32'(p));
      end
      if (k == 1) begin
        check("active_port", 32'(active_port), 32'(p));
        if (!hold) begin
          req = req & ~(4'd1 << p);
          set_byte(p, 8'($urandom));
        end
        if (noise) begin
          dbr      = $urandom;
          gap_bits = 8'($urandom);
          cts      = 1'b1;
        end
      end
      if (noise && k == len) begin
        cts      = 1'b0;
        dbr      = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 2));
        gap_bits = 8'($urandom_range(0, 3));
      end
      if (k == mid_k) dbr = mid_dbr;
      if (k == abort_k) begin
        reset = 1'b1;
        req   = 4'hF;
        #1;
        check("abort_txd", 32'(txd), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_gnt", 32'(gnt), 32'd0);
        rr = 0;
        return;
      end
    end
  endtask

  initial begin
    int g0;
    reset    = 1'b1;
    req      = 4'h0;
    data     = 32'h0;
    cts      = 1'b1;
    dbr      = 32'd1;
    gap_bits = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_active", 32'(active_port), 32'd0);
    req = 4'hF;
    cts = 1'b0;
    #1;
    check("rst_no_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    req   = 4'h0;
    cts   = 1'b1;
    reset = 1'b0;

    // Single 0x55 frame at minimum bit-time.
    @(negedge clk);
    set_byte(0, 8'h55);
    req = 4'b0001;
    cts = 1'b0;
    #1;
    do_frame(1'b0, 1'b0);
    check("t1_quiet", 32'(gnt), 32'd0);

    // All ports requesting, held: round-robin order and back-to-back spacing.
    @(negedge clk);
    data = 32'h3322_1100;
    req  = 4'hF;
    #1;
    do_frame(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      g0 = last_gnt;
      do_frame(1'b1, 1'b0);
      check("t2_interval", 32'(last_gnt - g0), 32'd193);
    end
    req = 4'h0;
    #1;
    check("t2_quiet", 32'(gnt), 32'd0);

    // cts gating and request withdrawal.
    @(negedge clk);
    cts = 1'b1;
    req = 4'b0010;
    repeat (4) begin
      @(negedge clk);
      check("t3_cts_gnt", 32'(gnt), 32'd0);
    end
    req = 4'b0000;
    cts = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("t3_withdraw", 32'(gnt), 32'd0);
      check("t3_withdraw_txd", 32'(txd), 32'd1);
    end
    cts = 1'b1;
    req = 4'b0100;
    repeat (20) begin
      @(negedge clk);
      check("t3_cts_gnt2", 32'(gnt), 32'd0);
      check("t3_cts_txd", 32'(txd), 32'd1);
    end
    cts = 1'b0;
    #1;
    do_frame(1'b0, 1'b0);
    check("t3_quiet", 32'(gnt), 32'd0);

    // Two-bit-time idle gap.
    @(negedge clk);
    gap_bits = 8'd2;
    dbr      = 32'd1;
    req      = 4'b0010;
    #1;
    do_frame(1'b1, 1'b0);
    g0 = last_gnt;
    do_frame(1'b0, 1'b0);
    check("t4_interval", 32'(last_gnt - g0), 32'd225);
    gap_bits = 8'd0;

    // Divisor change during data is ignored until the next frame.
    @(negedge clk);
    req     = 4'b0001;
    mid_k   = 40;
    mid_dbr = 32'd2;
    #1;
    do_frame(1'b1, 1'b0);
    mid_k = 0;
    g0 = last_gnt;
    do_frame(1'b0, 1'b0);
    check("t5_interval", 32'(last_gnt - g0), 32'd193);
    dbr = 32'd1;

    // Reset during data bit 4, then pointer restarts at port 0.
    @(negedge clk);
    req     = 4'b1000;
    abort_k = 90;
    #1;
    do_frame(1'b1, 1'b0);
    abort_k = 0;
    req = 4'b1001;
    repeat (2) begin
      @(negedge clk);
      check("t6_rst_gnt", 32'(gnt), 32'd0);
      check("t6_rst_txd", 32'(txd), 32'd1);
      check("t6_rst_busy", 32'(busy), 32'd0);
    end
    reset = 1'b0;
    #1;
    do_frame(1'b0, 1'b0);
    do_frame(1'b0, 1'b0);
    check("t6_quiet", 32'(gnt), 32'd0);

    // Randomized frames with config/cts noise during transmission.
    for (int it = 0; it < 12; it++) begin
      @(negedge clk);
      dbr      = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 2));
      gap_bits = 8'($urandom_range(0, 3));
      data     = $urandom;
      req      = 4'($urandom_range(1, 15));
      cts      = ($urandom_range(0, 3) == 0);
      if (cts) begin
        repeat (3) begin
          @(negedge clk);
          check("rnd_cts_gnt", 32'(gnt), 32'd0);
          check("rnd_cts_txd", 32'(txd), 32'd1);
        end
        cts = 1'b0;
      end
      #1;
      for (int f = 0; f < 3 && req != 4'h0; f++) begin
        do_frame(1'($urandom_range(0, 1)), 1'b1);
      end
      req = 4'h0;
      #1;
      check("rnd_quiet", 32'(gnt), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
